// File: rtl/i2c_cfg_sequencer_if.sv
// Command/response handshake between the config sequencer and a generic I2C master.
// The sequencer uses the master modport; the I2C master (or a model of it) uses slave.
interface i2c_cfg_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_nack;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Register-configuration sequencer for I2C CMOS sensors (e.g. AR0135).
// Walks a combinational LUT of {reg_addr, reg_data} entries and turns each into
// an I2C master command: entry 0 may be a chip-ID read-and-compare, addr == 0
// entries are delays, everything else is a register write with NACK retry.
// Optional macro CFG_READBACK_EN: every acknowledged write is followed by a
// read of the same register, and a data mismatch is treated as a failure.
module i2c_cfg_sequencer #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int INDEX_W       = 8,
    parameter int ID_CHECK      = 1,
    parameter int DELAY_UNIT    = 50000,
    parameter int DELAY_DEFAULT = 200,
    parameter int MAX_RETRY     = 3,
    parameter int AUTO_START    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_start_i,
    output logic [INDEX_W-1:0]       lut_index_o,
    input  logic [ADDR_W+DATA_W-1:0] lut_data_i,
    input  logic [INDEX_W-1:0]       lut_size_i,
    i2c_cfg_sequencer_if.master      i2c_bus,
    output logic                     cfg_busy_o,
    output logic                     cfg_done_o,
    output logic                     cfg_error_o,
    output logic                     id_ok_o,
    output logic [INDEX_W-1:0]       err_index_o
);
    localparam int                  PRESC_W     = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(DELAY_UNIT - 1);
    localparam logic [3:0]          RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [DATA_W-1:0]   DELAY_DEF   = DATA_W'(DELAY_DEFAULT);

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT_RSP, DELAY, NEXT, DONE, ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                is_id_q, is_id_d;
    logic [3:0]          retry_q, retry_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DATA_W-1:0]   unit_q, unit_d;
    logic                id_ok_q, id_ok_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [INDEX_W-1:0]  err_index_q, err_index_d;
    logic                start_pend_q, start_pend_d;
`ifdef CFG_READBACK_EN
    logic                rb_q, rb_d;
`endif

    logic [ADDR_W-1:0]   lut_addr;
    logic [DATA_W-1:0]   lut_wdata;
    logic                read_cmd;
    logic                rsp_fail;
    logic [INDEX_W:0]    index_inc;
    logic                last_entry;

    assign lut_addr  = lut_data_i[ADDR_W+DATA_W-1:DATA_W];
    assign lut_wdata = lut_data_i[DATA_W-1:0];

    // The outstanding command is a read either for the chip-ID entry or for a read-back.
`ifdef CFG_READBACK_EN
    assign read_cmd = is_id_q | rb_q;
`else
    assign read_cmd = is_id_q;
`endif

    // A read whose data differs from the entry's data fails just like a NACK.
    assign rsp_fail   = i2c_bus.rsp_nack || (read_cmd && (i2c_bus.rsp_rdata != data_q));
    assign index_inc  = {1'b0, index_q} + {{INDEX_W{1'b0}}, 1'b1};
    assign last_entry = (index_inc >= {1'b0, lut_size_i});

    assign i2c_bus.cmd_valid = (state_q == ISSUE);
    assign i2c_bus.cmd_rw    = read_cmd;
    assign i2c_bus.cmd_addr  = addr_q;
    assign i2c_bus.cmd_wdata = read_cmd ? '0 : data_q;

    assign lut_index_o = index_q;
    assign cfg_busy_o  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    assign cfg_done_o  = done_q;
    assign cfg_error_o = error_q;
    assign id_ok_o     = id_ok_q;
    assign err_index_o = err_index_q;

    // Next-state and register-update logic of the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        addr_d       = addr_q;
        data_d       = data_q;
        is_id_d      = is_id_q;
        retry_d      = retry_q;
        presc_d      = presc_q;
        unit_d       = unit_q;
        id_ok_d      = id_ok_q;
        done_d       = done_q;
        error_d      = error_q;
        err_index_d  = err_index_q;
        start_pend_d = start_pend_q;
`ifdef CFG_READBACK_EN
        rb_d         = rb_q;
`endif

        case (state_q)
            IDLE, DONE, ERROR: begin
                // The reset-release auto start is only pending while still in IDLE.
                if (init_start_i || start_pend_q) begin
                    start_pend_d = 1'b0;
                    index_d      = '0;
                    retry_d      = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    err_index_d  = '0;
                    id_ok_d      = (ID_CHECK == 0);
                    if (lut_size_i == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        id_ok_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            FETCH: begin
                addr_d  = lut_addr;
                data_d  = lut_wdata;
                is_id_d = (ID_CHECK != 0) && (index_q == '0);
`ifdef CFG_READBACK_EN
                rb_d    = 1'b0;
`endif
                if (is_id_d) begin
                    state_d = ISSUE;
                end else if (lut_addr == '0) begin
                    // Prescaler counts DELAY_UNIT cycles, unit counter counts N of them.
                    presc_d = PRESC_LAST;
                    unit_d  = (lut_wdata == '0) ? DELAY_DEF : lut_wdata;
                    state_d = DELAY;
                end else begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (i2c_bus.cmd_ready) begin
                    state_d = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (i2c_bus.rsp_valid) begin
                    if (rsp_fail) begin
                        // A retry always restarts the entry from its first command.
`ifdef CFG_READBACK_EN
                        rb_d = 1'b0;
`endif
                        if (retry_q < RETRY_LIMIT) begin
                            retry_d = retry_q + 4'd1;
                            state_d = ISSUE;
                        end else begin
                            error_d     = 1'b1;
                            err_index_d = index_q;
                            state_d     = ERROR;
                        end
                    end else begin
`ifdef CFG_READBACK_EN
                        if (!is_id_q && !rb_q) begin
                            rb_d    = 1'b1;
                            state_d = ISSUE;
                        end else begin
                            rb_d    = 1'b0;
                            state_d = NEXT;
                        end
`else
                        state_d = NEXT;
`endif
                        if (is_id_q) begin
                            id_ok_d = 1'b1;
                        end
                    end
                end
            end

            DELAY: begin
                if (presc_q == '0) begin
                    if (unit_q <= {{(DATA_W-1){1'b0}}, 1'b1}) begin
                        state_d = NEXT;
                    end else begin
                        unit_d  = unit_q - {{(DATA_W-1){1'b0}}, 1'b1};
                        presc_d = PRESC_LAST;
                    end
                end else begin
                    presc_d = presc_q - {{(PRESC_W-1){1'b0}}, 1'b1};
                end
            end

            NEXT: begin
                if (last_entry) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    index_d = index_inc[INDEX_W-1:0];
                    retry_d = '0;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            is_id_q      <= 1'b0;
            retry_q      <= '0;
            presc_q      <= '0;
            unit_q       <= '0;
            id_ok_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_index_q  <= '0;
            start_pend_q <= (AUTO_START != 0);
`ifdef CFG_READBACK_EN
            rb_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            is_id_q      <= is_id_d;
            retry_q      <= retry_d;
            presc_q      <= presc_d;
            unit_q       <= unit_d;
            id_ok_q      <= id_ok_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_index_q  <= err_index_d;
            start_pend_q <= start_pend_d;
`ifdef CFG_READBACK_EN
            rb_q         <= rb_d;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Self-checking bench for i2c_cfg_sequencer: directed LUT runs, an I2C master
// model replaying scripted responses, and a monitor scoreboarding every command.
module tb_i2c_cfg_sequencer;
    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        nack;
        logic [15:0] rdata;
        int          stall;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        init_start;
    logic [7:0]  lut_index;
    logic [31:0] lut_data;
    logic [7:0]  lut_size;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;
    logic        id_ok;
    logic [7:0]  err_index;

    logic [31:0] lut_mem [0:255];
    txn_t        exp_q[$];
    txn_t        rsp_q[$];
    int          checks;
    int          errors;
    int          txn_count;
    int          cnt2;
    int          cnt12;
    bit          stray_req;

    i2c_cfg_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    i2c_cfg_sequencer #(
        .ADDR_W(16), .DATA_W(16), .INDEX_W(8), .ID_CHECK(1),
        .DELAY_UNIT(4), .DELAY_DEFAULT(200), .MAX_RETRY(3), .AUTO_START(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .init_start_i(init_start),
        .lut_index_o(lut_index),
        .lut_data_i(lut_data),
        .lut_size_i(lut_size),
        .i2c_bus(bus),
        .cfg_busy_o(cfg_busy),
        .cfg_done_o(cfg_done),
        .cfg_error_o(cfg_error),
        .id_ok_o(id_ok),
        .err_index_o(err_index)
    );

    assign lut_data = lut_mem[lut_index];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Cycles spent on each delay entry (FETCH + DELAY + NEXT).
    initial begin
        cnt2 = 0;
        cnt12 = 0;
        forever begin
            @(negedge clk);
            if (init_start) begin
                cnt2 = 0;
                cnt12 = 0;
            end else if (cfg_busy) begin
                if (lut_index == 8'd2)  cnt2++;
                if (lut_index == 8'd12) cnt12++;
            end
        end
    end

    // I2C master model: accepts commands after a scripted stall, answers 2 cycles later.
    initial begin
        txn_t t;
        int   n;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        bus.rsp_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            bus.rsp_valid = stray_req;
            bus.rsp_nack  = stray_req;
            stray_req     = 1'b0;
            if (rst_n && bus.cmd_valid && rsp_q.size() > 0) begin
                t = rsp_q.pop_front();
                repeat (t.stall) begin @(posedge clk); #1; end
                bus.cmd_ready = 1'b1;
                n = 0;
                @(negedge clk);
                while (!bus.cmd_valid && n < 200) begin @(negedge clk); n++; end
                if (!bus.cmd_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL master_accept: cmd_valid=0 after %0d cycles, required 1", n);
                    bus.cmd_ready = 1'b0;
                end else begin
                    @(posedge clk); #1;
                    bus.cmd_ready = 1'b0;
                    repeat (2) begin @(posedge clk); #1; end
                    bus.rsp_valid = 1'b1;
                    bus.rsp_nack  = t.nack;
                    bus.rsp_rdata = t.rdata;
                    @(posedge clk); #1;
                    bus.rsp_valid = 1'b0;
                    bus.rsp_nack  = 1'b0;
                    bus.rsp_rdata = 16'h0;
                end
            end
        end
    end

    // Monitor: scoreboard each accepted command and check stability while stalled.
    initial begin
        txn_t        e;
        logic        held_v;
        logic [32:0] held;
        held_v = 1'b0;
        held   = '0;
        txn_count = 0;
        forever begin
            @(negedge clk);
            if (rst_n && held_v) begin
                checks++;
                if (!bus.cmd_valid || {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata} != held) begin
                    errors++;
                    $display("FAIL cmd_stable: got valid=%0d %h, required valid=1 %h",
                             bus.cmd_valid, {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata}, held);
                end
            end
            if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
                txn_count++;
                checks++;
                $display("TXN %0d rw=%0d addr=%h wdata=%h", txn_count, bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: got rw=%0d addr=%h wdata=%h, required no command",
                             bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.cmd_rw !== e.rw || bus.cmd_addr !== e.addr || bus.cmd_wdata !== e.wdata) begin
                        errors++;
                        $display("FAIL cmd_txn%0d: got rw=%0d addr=%h wdata=%h, required rw=%0d addr=%h wdata=%h",
                                 txn_count, bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata, e.rw, e.addr, e.wdata);
                    end
                end
            end
            held_v = rst_n && bus.cmd_valid && !bus.cmd_ready;
            held   = {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                        input logic nk, input logic [15:0] rd, input int st);
        txn_t t;
        t.rw = rw; t.addr = a; t.wdata = wd; t.nack = nk; t.rdata = rd; t.stall = st;
        exp_q.push_back(t);
        rsp_q.push_back(t);
    endtask

    task automatic push_write(input logic [15:0] a, input logic [15:0] d);
        push(1'b0, a, d, 1'b0, 16'h0, 0);
`ifdef CFG_READBACK_EN
        push(1'b1, a, 16'h0, 1'b0, d, 0);
`endif
    endtask

    task automatic push_id_ok();
        push(1'b1, 16'h3000, 16'h0, 1'b0, 16'h0554, 0);
    endtask

    task automatic push_table(input int first, input int last);
        logic [31:0] ent;
        for (int i = first; i <= last; i++) begin
            ent = lut_mem[i];
            if (i == 0) push_id_ok();
            else if (ent[31:16] != 16'h0) push_write(ent[31:16], ent[15:0]);
        end
    endtask

    task automatic start_seq();
        @(posedge clk); #1 init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (cfg_busy && n < limit) begin @(negedge clk); n++; end
        chk({name, " finish"}, {31'h0, cfg_busy}, 32'h0);
    endtask

    task automatic check_status(input string name, input logic d, input logic e, input logic ok,
                                input logic [7:0] ei, input logic [7:0] li);
        chk({name, " cfg_done"}, {31'h0, cfg_done}, {31'h0, d});
        chk({name, " cfg_error"}, {31'h0, cfg_error}, {31'h0, e});
        chk({name, " id_ok"}, {31'h0, id_ok}, {31'h0, ok});
        chk({name, " err_index"}, {24'h0, err_index}, {24'h0, ei});
        chk({name, " lut_index"}, {24'h0, lut_index}, {24'h0, li});
        chk({name, " pending_cmds"}, exp_q.size(), 32'h0);
        exp_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stray_req = 1'b0;
        rst_n = 1'b0;
        init_start = 1'b0;
        lut_size = 8'd2;
        for (int i = 0; i < 256; i++) lut_mem[i] = 32'h0;
        lut_mem[0]  = 32'h3000_0554; lut_mem[1]  = 32'h301A_0001;
        lut_mem[2]  = 32'h0000_0000; lut_mem[3]  = 32'h301A_10D8;
        lut_mem[4]  = 32'h3088_8000; lut_mem[5]  = 32'h3086_0025;
        lut_mem[6]  = 32'h3086_7316; lut_mem[7]  = 32'h3086_8000;
        lut_mem[8]  = 32'h302A_0006; lut_mem[9]  = 32'h302C_0001;
        lut_mem[10] = 32'h302E_0002; lut_mem[11] = 32'h3030_002C;
        lut_mem[12] = 32'h0000_0000; lut_mem[13] = 32'h3032_0000;
        lut_mem[14] = 32'h3002_0000; lut_mem[15] = 32'h3004_0000;
        lut_mem[16] = 32'h3006_03BF; lut_mem[17] = 32'h3008_04FF;
        lut_mem[18] = 32'h300A_03DE; lut_mem[19] = 32'h300C_0672;
        lut_mem[20] = 32'h3012_0100; lut_mem[21] = 32'h30B0_0080;
        lut_mem[22] = 32'h3064_1982; lut_mem[23] = 32'h301A_10DC;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {bus.cmd_valid, cfg_busy, cfg_done, cfg_error, id_ok, err_index, lut_index},
            32'h0);
        chk("reset cmd_addr", {16'h0, bus.cmd_addr}, 32'h0);

        // Auto start after reset: chip-ID read then one write.
        push_id_ok();
        push_write(16'h301A, 16'h0001);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_idle("autostart_id", 500);
        check_status("autostart_id", 1'b1, 1'b0, 1'b1, 8'd0, 8'd1);

        // Full 24-entry table with two default delays of 200 units.
        lut_size = 8'd24;
        push_table(0, 23);
        start_seq();
        wait_idle("full_table", 5000);
        check_status("full_table", 1'b1, 1'b0, 1'b1, 8'd0, 8'd23);
        chk("full_table delay2 cycles", cnt2, 32'd802);
        chk("full_table delay12 cycles", cnt12, 32'd802);

        // Entry 3 NACKed twice, then acknowledged.
        lut_size = 8'd5;
        push_table(0, 2);
        push(1'b0, 16'h301A, 16'h10D8, 1'b1, 16'h0, 0);
        push(1'b0, 16'h301A, 16'h10D8, 1'b1, 16'h0, 0);
        push_write(16'h301A, 16'h10D8);
        push_table(4, 4);
        start_seq();
        wait_idle("nack_retry", 3000);
        check_status("nack_retry", 1'b1, 1'b0, 1'b1, 8'd0, 8'd4);

        // Chip ID wrong on every attempt.
        lut_size = 8'd24;
        repeat (4) push(1'b1, 16'h3000, 16'h0, 1'b0, 16'h0555, 0);
        start_seq();
        wait_idle("id_mismatch", 500);
        check_status("id_mismatch", 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

        // Entry 1 NACKed on all four attempts.
        lut_size = 8'd5;
        push_id_ok();
        repeat (4) push(1'b0, 16'h301A, 16'h0001, 1'b1, 16'h0, 0);
        start_seq();
        wait_idle("nack_exhaust", 500);
        check_status("nack_exhaust", 1'b0, 1'b1, 1'b1, 8'd1, 8'd1);

        // Stalled cmd_ready, init_start while busy, stray rsp_valid during a 3-unit delay.
        lut_size = 8'd4;
        lut_mem[2] = 32'h0000_0003;
        push(1'b1, 16'h3000, 16'h0, 1'b0, 16'h0554, 10);
        push_write(16'h301A, 16'h0001);
        push_write(16'h301A, 16'h10D8);
        start_seq();
        repeat (4) @(posedge clk);
        #1 init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
        for (int n = 0; n < 300 && lut_index != 8'd2; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        stray_req = 1'b1;
        wait_idle("stall_stray", 1000);
        check_status("stall_stray", 1'b1, 1'b0, 1'b1, 8'd0, 8'd3);
        chk("stall_stray delay2 cycles", cnt2, 32'd14);

        // Empty table completes at once without an ID.
        lut_size = 8'd0;
        start_seq();
        @(negedge clk);
        chk("empty busy", {31'h0, cfg_busy}, 32'h0);
        check_status("empty", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

`ifdef CFG_READBACK_EN
        // Read-back of 302C returns stale data twice before matching.
        lut_size = 8'd10;
        push_table(0, 8);
        push(1'b0, 16'h302C, 16'h0001, 1'b0, 16'h0, 0);
        push(1'b1, 16'h302C, 16'h0,    1'b0, 16'h0000, 0);
        push(1'b0, 16'h302C, 16'h0001, 1'b0, 16'h0, 0);
        push(1'b1, 16'h302C, 16'h0,    1'b0, 16'h0000, 0);
        push(1'b0, 16'h302C, 16'h0001, 1'b0, 16'h0, 0);
        push(1'b1, 16'h302C, 16'h0,    1'b0, 16'h0001, 0);
        start_seq();
        wait_idle("readback", 2000);
        check_status("readback", 1'b1, 1'b0, 1'b1, 8'd0, 8'd9);
`endif

        // Reset while a command is held: cmd_valid must drop, then auto start reruns.
        lut_size = 8'd1;
        push(1'b1, 16'h3000, 16'h0, 1'b0, 16'h0554, 20);
        start_seq();
        repeat (5) @(negedge clk);
        chk("midreset cmd_valid before", {31'h0, bus.cmd_valid}, 32'h1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset cmd_valid", {31'h0, bus.cmd_valid}, 32'h0);
        chk("midreset busy", {31'h0, cfg_busy}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_idle("midreset", 500);
        check_status("midreset", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
